// File: rtl/pin_activity_monitor.sv
// Per-pin edge monitor: synchronises probe pins, counts edges per fixed window,
// keeps sticky activity flags and exposes one selected channel plus LED heartbeats.
module pin_activity_monitor #(
    parameter int unsigned NUM_CH     = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WIN_CYCLES = 25000000,
    parameter int unsigned SEL_W      = 8
) (
    input  logic              clk25,
    input  logic              rst_,
    input  logic [NUM_CH-1:0] pins_in,
    input  logic              clr,
    input  logic [SEL_W-1:0]  sel,
    output logic [CNT_W-1:0]  sel_count,
    output logic              sel_active,
    output logic [NUM_CH-1:0] active_mask,
    output logic              any_active,
    output logic              win_done,
    output logic              heartbeat,
    output logic              xtal_out
);

    localparam int unsigned WCNT_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WIN_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WIN_PRE  = WCNT_W'(WIN_CYCLES - 2);

    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s2;
    logic [NUM_CH-1:0] s3;
    logic [1:0]        arm;
    logic [WCNT_W-1:0] wcnt;
    logic [CNT_W-1:0]  live    [NUM_CH];
    logic [CNT_W-1:0]  latched [NUM_CH];

    logic [CNT_W-1:0]  live_next_c [NUM_CH];
    logic [NUM_CH-1:0] edge_c;
    logic              win_end_c;
    logic [CNT_W-1:0]  sel_count_c;
    logic              sel_active_c;

    // Two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pins_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Edges are masked until the sync chain has filled after reset
    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            arm <= 2'd0;
        end else if (arm != 2'd3) begin
            arm <= arm + 2'd1;
        end
    end

    assign edge_c    = (arm == 2'd3) ? (s2 ^ s3) : '0;
    assign win_end_c = (wcnt == WIN_LAST);

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            live_next_c[i] = live[i];
            if (edge_c[i] && (live[i] != CNT_MAX)) begin
                live_next_c[i] = live[i] + CNT_W'(1);
            end
        end
    end

    // Window timing, sticky flags and heartbeat
    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            wcnt        <= '0;
            win_done    <= 1'b0;
            heartbeat   <= 1'b0;
            active_mask <= '0;
        end else if (clr) begin
            wcnt        <= '0;
            win_done    <= 1'b0;
            active_mask <= '0;
        end else begin
            wcnt        <= win_end_c ? '0 : wcnt + WCNT_W'(1);
            win_done    <= (wcnt == WIN_PRE);
            active_mask <= active_mask | edge_c;
            if (win_end_c) begin
                heartbeat <= ~heartbeat;
            end
        end
    end

    // Live counters roll into the latched bank at window end, same-cycle edge included
    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                live[i]    <= '0;
                latched[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                live[i]    <= '0;
                latched[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (win_end_c) begin
                    latched[i] <= live_next_c[i];
                    live[i]    <= '0;
                end else begin
                    live[i]    <= live_next_c[i];
                end
            end
        end
    end

    // Out-of-range select matches no channel and reads zero
    always_comb begin
        sel_count_c  = '0;
        sel_active_c = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (32'(sel) == 32'(i)) begin
                sel_count_c  = latched[i];
                sel_active_c = active_mask[i];
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            sel_count  <= '0;
            sel_active <= 1'b0;
        end else if (clr) begin
            sel_count  <= '0;
            sel_active <= 1'b0;
        end else begin
            sel_count  <= sel_count_c;
            sel_active <= sel_active_c;
        end
    end

    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            xtal_out <= 1'b0;
        end else begin
            xtal_out <= ~xtal_out;
        end
    end

    assign any_active = |active_mask;

endmodule

// File: tb/tb_pin_activity_monitor.sv
// Self-checking bench for pin_activity_monitor: directed window/readout tables
// plus randomized traffic compared every cycle against a rule-level model.
`timescale 1ns/1ps
module tb_pin_activity_monitor;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WIN    = 16;
    localparam int unsigned SEL_W  = 2;
    localparam int          CNT_MAX = 15;

    logic             clk25 = 1'b0;
    logic             rst_  = 1'b0;
    logic [3:0]       pins_in = '0;
    logic             clr = 1'b0;
    logic [1:0]       sel = '0;
    logic [3:0]       sel_count;
    logic             sel_active;
    logic [3:0]       active_mask;
    logic             any_active;
    logic             win_done;
    logic             heartbeat;
    logic             xtal_out;

    pin_activity_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_CYCLES(WIN), .SEL_W(SEL_W)
    ) dut (
        .clk25(clk25), .rst_(rst_), .pins_in(pins_in), .clr(clr), .sel(sel),
        .sel_count(sel_count), .sel_active(sel_active), .active_mask(active_mask),
        .any_active(any_active), .win_done(win_done), .heartbeat(heartbeat),
        .xtal_out(xtal_out)
    );

    always #20 clk25 = ~clk25;

    int checks   = 0;
    int failures = 0;

    // Reference model: edge counting from the history of sampled pin values
    logic [3:0] samp[$];
    int         m_live[4];
    int         m_lat[4];
    logic [3:0] m_act;
    int         m_wpos;
    logic       m_hb, m_wd, m_xt, m_sa;
    logic [3:0] m_cnt;

    logic [3:0] pins_cur = '0;
    logic [1:0] sel_cur  = '0;

    typedef struct {
        int         phase;
        logic [1:0] sel;
        logic [3:0] cnt;
        logic       act;
        logic [3:0] mask;
    } rd_t;
    rd_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        samp.delete();
        for (int i = 0; i < 4; i++) begin
            m_live[i] = 0;
            m_lat[i]  = 0;
        end
        m_act = '0; m_wpos = 0; m_hb = 0; m_wd = 0; m_xt = 0; m_sa = 0; m_cnt = '0;
    endfunction

    // A change between consecutive samples k and k+1 is counted at edge k+3 once armed
    function automatic void model_edge(input logic [3:0] p, input logic c, input logic [1:0] s);
        int m;
        logic [3:0] ev;
        samp.push_back(p);
        m  = samp.size();
        ev = '0;
        if (m >= 4) ev = samp[m-3] ^ samp[m-4];
        if (c) begin
            for (int i = 0; i < 4; i++) begin
                m_live[i] = 0;
                m_lat[i]  = 0;
            end
            m_act = '0; m_wpos = 0; m_cnt = '0; m_sa = 0;
        end else begin
            m_cnt = 4'(m_lat[s]);
            m_sa  = m_act[s];
            for (int i = 0; i < 4; i++) begin
                if (ev[i]) begin
                    if (m_live[i] < CNT_MAX) m_live[i]++;
                    m_act[i] = 1'b1;
                end
            end
            if (m_wpos == int'(WIN) - 1) begin
                for (int i = 0; i < 4; i++) begin
                    m_lat[i]  = m_live[i];
                    m_live[i] = 0;
                end
                m_hb = ~m_hb;
            end
            m_wpos = (m_wpos + 1) % int'(WIN);
        end
        m_wd = !c && (m_wpos == int'(WIN) - 1);
        m_xt = ~m_xt;
    endfunction

    task automatic step(input logic c, input logic [1:0] s);
        pins_in = pins_cur;
        clr     = c;
        sel     = s;
        @(posedge clk25);
        model_edge(pins_cur, c, s);
        #1;
        chk("cycle{cnt,sa,mask,any,wd,hb,xt}",
            32'({sel_count, sel_active, active_mask, any_active, win_done, heartbeat, xtal_out}),
            32'({m_cnt, m_sa, m_act, |m_act, m_wd, m_hb, m_xt}));
        clr = 1'b0;
    endtask

    task automatic run_until_wd(input int budget, output int n);
        n = 0;
        do begin
            step(1'b0, sel_cur);
            n++;
        end while (win_done !== 1'b1 && n < budget);
        if (win_done !== 1'b1) chk("win_done_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_table(input int phase);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].phase == phase) begin
                sel_cur = tbl[i].sel;
                step(1'b0, sel_cur);
                chk($sformatf("p%0d_sel%0d_count", phase, tbl[i].sel), 32'(sel_count), 32'(tbl[i].cnt));
                chk($sformatf("p%0d_sel%0d_active", phase, tbl[i].sel), 32'(sel_active), 32'(tbl[i].act));
                chk($sformatf("p%0d_mask", phase), 32'(active_mask), 32'(tbl[i].mask));
                chk($sformatf("p%0d_any", phase), 32'(any_active), 32'(|tbl[i].mask));
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 32'({sel_count, sel_active, active_mask, any_active, win_done, heartbeat, xtal_out}), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int wd_at[$];
        logic hb15, hb16, hb32, hb_exp;

        tbl[0]  = '{1, 2'd2, 4'd5,  1'b1, 4'b0100};
        tbl[1]  = '{1, 2'd1, 4'd0,  1'b0, 4'b0100};
        tbl[2]  = '{1, 2'd0, 4'd0,  1'b0, 4'b0100};
        tbl[3]  = '{2, 2'd3, 4'd1,  1'b1, 4'b1100};
        tbl[4]  = '{2, 2'd2, 4'd0,  1'b1, 4'b1100};
        tbl[5]  = '{3, 2'd3, 4'd0,  1'b1, 4'b1100};
        tbl[6]  = '{4, 2'd0, 4'd15, 1'b1, 4'b1101};
        tbl[7]  = '{4, 2'd3, 4'd0,  1'b1, 4'b1101};
        tbl[8]  = '{5, 2'd0, 4'd0,  1'b0, 4'b0000};
        tbl[9]  = '{5, 2'd2, 4'd0,  1'b0, 4'b0000};
        tbl[10] = '{6, 2'd1, 4'd0,  1'b0, 4'b0000};
        tbl[11] = '{6, 2'd3, 4'd0,  1'b0, 4'b0000};

        // Reset state, then 40 quiet cycles
        model_reset();
        #5;
        check_all_zero("reset_outputs");
        @(negedge clk25);
        rst_ = 1'b1;
        hb15 = 1'bx; hb16 = 1'bx; hb32 = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, sel_cur);
            if (win_done === 1'b1) wd_at.push_back(k);
            if (k == 15) hb15 = heartbeat;
            if (k == 16) hb16 = heartbeat;
            if (k == 32) hb32 = heartbeat;
        end
        chk("quiet_wd_pulses", 32'(wd_at.size()), 32'(2));
        if (wd_at.size() >= 2) begin
            chk("quiet_wd_first", 32'(wd_at[0]), 32'(15));
            chk("quiet_wd_second", 32'(wd_at[1]), 32'(31));
        end
        chk("quiet_hb_c15", 32'(hb15), 32'(0));
        chk("quiet_hb_c16", 32'(hb16), 32'(1));
        chk("quiet_hb_c32", 32'(hb32), 32'(0));
        chk("quiet_mask", 32'(active_mask), 32'(0));

        // Five edges on pin 2 inside one window
        run_until_wd(40, n);
        step(1'b0, sel_cur);
        for (int t = 0; t < 5; t++) begin
            pins_cur[2] = ~pins_cur[2];
            step(1'b0, sel_cur);
            step(1'b0, sel_cur);
        end
        run_until_wd(40, n);
        step(1'b0, sel_cur);
        run_table(1);

        // Single pin 3 edge reaching the counter in the last window cycle
        run_until_wd(40, n);
        step(1'b0, sel_cur);
        for (int t = 0; t < int'(WIN) - 3; t++) step(1'b0, sel_cur);
        pins_cur[3] = ~pins_cur[3];
        step(1'b0, sel_cur);
        run_until_wd(40, n);
        chk("boundary_wd_steps", 32'(n), 32'(1));
        step(1'b0, sel_cur);
        run_table(2);
        run_until_wd(40, n);
        step(1'b0, sel_cur);
        run_table(3);

        // Pin 0 toggling every cycle: counter saturates and never wraps
        run_until_wd(40, n);
        step(1'b0, sel_cur);
        for (int t = 0; t < 2 * int'(WIN); t++) begin
            pins_cur[0] = ~pins_cur[0];
            step(1'b0, sel_cur);
        end
        run_table(4);

        // Synchronous clear mid-window
        for (int t = 0; t < 5; t++) step(1'b0, 2'd0);
        chk("pre_clr_mask", 32'(active_mask), 32'(4'b1101));
        hb_exp = m_hb;
        step(1'b1, 2'd0);
        chk("clr_mask", 32'(active_mask), 32'(0));
        chk("clr_sel_count", 32'(sel_count), 32'(0));
        chk("clr_win_done", 32'(win_done), 32'(0));
        chk("clr_heartbeat_held", 32'(heartbeat), 32'(hb_exp));
        sel_cur = 2'd0;
        run_until_wd(40, n);
        chk("clr_to_wd_steps", 32'(n), 32'(WIN - 1));
        step(1'b0, sel_cur);
        run_table(5);

        // Pins held high through an asynchronous mid-window reset
        pins_cur = 4'b1111;
        for (int t = 0; t < 7; t++) step(1'b0, sel_cur);
        #7;
        rst_ = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        model_reset();
        @(posedge clk25);
        @(negedge clk25);
        rst_ = 1'b1;
        for (int t = 0; t < 40; t++) step(1'b0, sel_cur);
        chk("rearm_mask", 32'(active_mask), 32'(0));
        run_table(6);

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            pins_cur = pins_cur ^ (4'($urandom) & 4'($urandom));
            sel_cur  = 2'($urandom);
            step(($urandom_range(0, 39) == 0), sel_cur);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
